bch15_7_serial_decoder: RTL and testbench
=========================================

// Module: bch15_7_serial_decoder
// PURPOSE
//  Bit-serial receive-side decoder for the BCH(15,7,2) link. Shifts in one 15-bit codeword
//  {msg[6:0],parity[7:0]}, computes S1/S3 over GF(16) (x^4+x+1, alpha=2), solves the
//  2-error locator, then runs a sequential Chien search. Presents the corrected 7-bit
//  message with a status code on a valid/ready output. Generator polynomial is 9'h1D1.
// PARAMETERS
//  MSB_FIRST  1  1: first serial bit is r[14]; 0: first serial bit is r[0]
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  in_valid     in   1  in_bit is valid this cycle
//  in_bit       in   1  serial codeword bit
//  in_ready     out  1  decoder accepts a bit (high only in RECV)
//  out_valid    out  1  out_msg/out_status are valid
//  out_ready    in   1  downstream consumes the result
//  out_msg      out  7  corrected message (r[14:8] after correction)
//  out_status   out  2  0=clean, 1=one error fixed, 2=two errors fixed, 3=uncorrectable
// BEHAVIOUR
//  - Reset (async, any state): state=RECV, bit count=0, rx=0, flip mask=0, root count=0;
//    in_ready=1 on the first edge after release; out_valid=0, out_msg=0, out_status=0.
//  - RECV: a bit is accepted on an edge where in_valid&&in_ready and is placed at r[14-n]
//    (MSB_FIRST=1) or r[n] (MSB_FIRST=0), n=0..14. The 15th accept moves to LOCATE.
//    in_valid low only stalls; the count holds.
//  - LOCATE (1 cycle): S1=XOR alpha^i, S3=XOR alpha^(3i mod 15) over set r[i]. Register
//    sigma1=S1 and sigma2=(S3^S1^3)/S1 (0 if S1==0 or numerator==0). Then go to CHIEN.
//  - CHIEN (15 cycles): cycle k evaluates sigma(alpha^-j) for j=14-k, j=14 first.
//    On a zero result, roots++ (saturates at 3). If j>=8, also set flip bit j-8.
//    After j=0, go to DONE.
//  - DONE: out_valid=1; out_msg/out_status are held stable until out_valid&&out_ready.
//    On that edge, go to RECV with in_ready=1 and out_valid=0 the next cycle. in_ready=0
//    in LOCATE, CHIEN and DONE; there is no overlap of codewords.
//  - Status, decided on entry to DONE:
//      S1==0 && S3==0                    -> 0, msg=r[14:8]
//      S1==0 && S3!=0                    -> 3
//      sigma2==0 && roots==1             -> 1
//      sigma2!=0 && roots==2             -> 2
//      any other combination             -> 3
//    For status 3, out_msg=r[14:8] uncorrected; the flip mask is discarded.
//  - Parity-position roots (j<8) count toward roots but never alter out_msg.
//  - Latency: with the 15th-bit accept edge as edge 0, out_valid rises after edge 17.
//  - All GF ops are 4-bit. Log/antilog use mod-15 exponent arithmetic. log(0) is never used
//    (guarded by zero checks).
// CONFIGURATION
//  BCH_SYND_BYPASS_EN defined: in LOCATE, if S1==0 && S3==0, skip CHIEN and go to DONE.
//    out_valid rises after edge 2 with status 0. Non-zero syndromes keep latency 17.
//  Undefined: every codeword runs the full 15-cycle CHIEN; latency is always 17.
// TESTING
//  1 Assert rst mid-CHIEN -> out_valid=0 and in_ready=0 immediately; after release,
//    in_ready=1, a fresh 15'h01D1 decodes to msg 7'h01, status 0.
//  2 Clean 15'h01D1 sent MSB-first with random in_valid gaps -> msg 7'h01, status 0;
//    out_valid after edge 17 (edge 2 with BCH_SYND_BYPASS_EN).
//  3 15'h3FFF (codeword 15'h7FFF, bit 14 flipped) -> msg 7'h7F, status 1.
//  4 15'h2004 (zero codeword, bits 13 and 2 flipped) -> msg 7'h00, status 2.
//  5 15'h0007 (3 errors on zero codeword) -> miscorrection at j=13 and j=9,
//    msg 7'h22, status 2 (matches golden model).
//  6 out_ready held low 20 cycles in DONE -> out_msg/out_status stable and in_ready=0;
//    accept on out_ready=1, then in_ready=1 next cycle. Repeat all tests with MSB_FIRST=0.

Source files
------------

// File: rtl/bch15_7_serial_decoder_if.sv
// rtl/bch15_7_serial_decoder_if.sv - serial codeword in / corrected message out handshake bundle
interface bch15_7_serial_decoder_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_msg;
  logic [1:0] out_status;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_msg, out_status
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_msg, out_status
  );
endinterface

// File: rtl/bch15_7_serial_decoder.sv
// rtl/bch15_7_serial_decoder.sv - bit-serial BCH(15,7,2) decoder: syndromes, locator, Chien search
// Optional BCH_SYND_BYPASS_EN: zero-syndrome codewords skip the Chien search.
module bch15_7_serial_decoder #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  bch15_7_serial_decoder_if.slave bus
);

  typedef enum logic [1:0] {RECV, LOCATE, CHIEN, DONE} state_t;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] sh;
    p  = 4'h0;
    sh = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ sh;
      sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_exp(input logic [3:0] e);
    logic [3:0] v;
    case (e)
      4'd0:    v = 4'h1;
      4'd1:    v = 4'h2;
      4'd2:    v = 4'h4;
      4'd3:    v = 4'h8;
      4'd4:    v = 4'h3;
      4'd5:    v = 4'h6;
      4'd6:    v = 4'hC;
      4'd7:    v = 4'hB;
      4'd8:    v = 4'h5;
      4'd9:    v = 4'hA;
      4'd10:   v = 4'h7;
      4'd11:   v = 4'hE;
      4'd12:   v = 4'hF;
      4'd13:   v = 4'hD;
      4'd14:   v = 4'h9;
      default: v = 4'h1;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] gf_log(input logic [3:0] a);
    logic [3:0] v;
    case (a)
      4'h1:    v = 4'd0;
      4'h2:    v = 4'd1;
      4'h4:    v = 4'd2;
      4'h8:    v = 4'd3;
      4'h3:    v = 4'd4;
      4'h6:    v = 4'd5;
      4'hC:    v = 4'd6;
      4'hB:    v = 4'd7;
      4'h5:    v = 4'd8;
      4'hA:    v = 4'd9;
      4'h7:    v = 4'd10;
      4'hE:    v = 4'd11;
      4'hF:    v = 4'd12;
      4'hD:    v = 4'd13;
      4'h9:    v = 4'd14;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] rx_q, rx_d;
  logic [3:0]  j_q, j_d;
  logic [1:0]  roots_q, roots_d;
  logic [6:0]  flip_q, flip_d;
  logic [3:0]  sigma2_q, sigma2_d;
  logic [3:0]  term1_q, term1_d;
  logic [3:0]  term2_q, term2_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s3_zero_q, s3_zero_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [6:0]  out_msg_q, out_msg_d;
  logic [1:0]  out_status_q, out_status_d;

  logic [3:0]  pos;
  logic [3:0]  s1, s3, num, sig2;
  logic [4:0]  e_diff;

  assign pos = MSB_FIRST ? (4'd14 - cnt_q) : cnt_q;

  // Syndromes and sigma2 = (S3 + S1^3) / S1, evaluated from the full received word.
  always_comb begin
    s1 = 4'h0;
    s3 = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (rx_q[i]) begin
        s1 = s1 ^ gf_exp(4'(i));
        s3 = s3 ^ gf_exp(4'((3 * i) % 15));
      end
    end
    num    = s3 ^ gf_mul(s1, gf_mul(s1, s1));
    e_diff = {1'b0, gf_log(num)} + 5'd15 - {1'b0, gf_log(s1)};
    if (e_diff >= 5'd15) e_diff = e_diff - 5'd15;
    sig2   = (s1 == 4'h0 || num == 4'h0) ? 4'h0 : gf_exp(e_diff[3:0]);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    j_d          = j_q;
    roots_d      = roots_q;
    flip_d       = flip_q;
    sigma2_d     = sigma2_q;
    term1_d      = term1_q;
    term2_d      = term2_q;
    s1_zero_d    = s1_zero_q;
    s3_zero_d    = s3_zero_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_msg_d    = out_msg_q;
    out_status_d = out_status_q;
    case (state_q)
      RECV: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          rx_d[pos] = bus.in_bit;
          if (cnt_q == 4'd14) begin
            cnt_d      = 4'd0;
            state_d    = LOCATE;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      LOCATE: begin
        // Chien terms start at alpha^-14 = alpha^1 and step by alpha / alpha^2 per cycle.
        sigma2_d  = sig2;
        term1_d   = gf_mul(s1, 4'h2);
        term2_d   = gf_mul(sig2, 4'h4);
        s1_zero_d = (s1 == 4'h0);
        s3_zero_d = (s3 == 4'h0);
        roots_d   = 2'd0;
        flip_d    = 7'h00;
        j_d       = 4'd14;
        state_d   = CHIEN;
`ifdef BCH_SYND_BYPASS_EN
        if (s1 == 4'h0 && s3 == 4'h0) state_d = DONE;
`endif
      end
      CHIEN: begin
        if ((4'h1 ^ term1_q ^ term2_q) == 4'h0) begin
          if (roots_q != 2'd3) roots_d = roots_q + 2'd1;
          if (j_q[3]) flip_d[j_q[2:0]] = 1'b1;
        end
        term1_d = gf_mul(term1_q, 4'h2);
        term2_d = gf_mul(term2_q, 4'h4);
        if (j_q == 4'd0) state_d = DONE;
        else             j_d     = j_q - 4'd1;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d  = 1'b1;
          out_msg_d    = rx_q[14:8];
          out_status_d = 2'd3;
          if (s1_zero_q) begin
            out_status_d = s3_zero_q ? 2'd0 : 2'd3;
          end else if (sigma2_q == 4'h0 && roots_q == 2'd1) begin
            out_status_d = 2'd1;
            out_msg_d    = rx_q[14:8] ^ flip_q;
          end else if (sigma2_q != 4'h0 && roots_q == 2'd2) begin
            out_status_d = 2'd2;
            out_msg_d    = rx_q[14:8] ^ flip_q;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RECV;
      cnt_q        <= 4'd0;
      rx_q         <= 15'h0000;
      j_q          <= 4'd0;
      roots_q      <= 2'd0;
      flip_q       <= 7'h00;
      sigma2_q     <= 4'h0;
      term1_q      <= 4'h0;
      term2_q      <= 4'h0;
      s1_zero_q    <= 1'b0;
      s3_zero_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_msg_q    <= 7'h00;
      out_status_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      j_q          <= j_d;
      roots_q      <= roots_d;
      flip_q       <= flip_d;
      sigma2_q     <= sigma2_d;
      term1_q      <= term1_d;
      term2_q      <= term2_d;
      s1_zero_q    <= s1_zero_d;
      s3_zero_q    <= s3_zero_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_msg_q    <= out_msg_d;
      out_status_q <= out_status_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_msg    = out_msg_q;
  assign bus.out_status = out_status_q;

endmodule

// File: tb/tb_bch15_7_serial_decoder.sv
// tb/tb_bch15_7_serial_decoder.sv - randomized bench for both bit orders against a GF(16) reference decoder
module tb_bch15_7_serial_decoder;

`ifdef BCH_SYND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ivld = 1'b0;
  logic bit_a = 1'b0;
  logic bit_b = 1'b0;
  logic ordy = 1'b0;
  logic checking = 1'b0;

  int total = 0;
  int bad = 0;

  bch15_7_serial_decoder_if ifa ();
  bch15_7_serial_decoder_if ifb ();

  assign ifa.in_valid  = ivld;
  assign ifb.in_valid  = ivld;
  assign ifa.in_bit    = bit_a;
  assign ifb.in_bit    = bit_b;
  assign ifa.out_ready = ordy;
  assign ifb.out_ready = ordy;

  bch15_7_serial_decoder #(.MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bch15_7_serial_decoder #(.MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference GF(16) arithmetic from first principles: repeated multiply by x mod x^4+x+1.
  function automatic int gexp(input int e);
    int v;
    v = 1;
    for (int k = 0; k < e % 15; k++) begin
      v = v << 1;
      if (v >= 16) v = v ^ 19;
    end
    return v;
  endfunction

  function automatic int glog(input int a);
    for (int k = 0; k < 15; k++) if (gexp(k) == a) return k;
    return 0;
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp((glog(a) + glog(b)) % 15);
  endfunction

  // Result packed as {clean, status[1:0], msg[6:0]}.
  function automatic logic [9:0] model_res(input logic [14:0] r);
    int s1, s3, num, sg2, roots, x, v;
    logic [6:0] flip;
    logic [1:0] st;
    logic       clean;
    s1 = 0; s3 = 0; roots = 0; flip = 7'h00;
    for (int i = 0; i < 15; i++) begin
      if (r[i]) begin
        s1 = s1 ^ gexp(i);
        s3 = s3 ^ gexp(3 * i);
      end
    end
    clean = (s1 == 0 && s3 == 0);
    if (s1 == 0) return {clean, clean ? 2'd0 : 2'd3, r[14:8]};
    num = s3 ^ gmul(s1, gmul(s1, s1));
    sg2 = (num == 0) ? 0 : gexp((glog(num) - glog(s1) + 15) % 15);
    for (int j = 0; j < 15; j++) begin
      x = gexp(15 - j);
      v = 1 ^ gmul(s1, x) ^ gmul(sg2, gmul(x, x));
      if (v == 0) begin
        roots++;
        if (j >= 8) flip[j - 8] = 1'b1;
      end
    end
    if (roots > 3) roots = 3;
    if (sg2 == 0 && roots == 1)      st = 2'd1;
    else if (sg2 != 0 && roots == 2) st = 2'd2;
    else                             st = 2'd3;
    return {1'b0, st, (st == 2'd3) ? r[14:8] : (r[14:8] ^ flip)};
  endfunction

  function automatic logic [14:0] encode(input logic [6:0] m);
    int rem;
    rem = int'(m) << 8;
    for (int b = 14; b >= 8; b--) if (rem & (1 << b)) rem = rem ^ ('h1D1 << (b - 8));
    return {m, rem[7:0]};
  endfunction

  function automatic logic [14:0] put_bit(input logic [14:0] w, input int n, input logic b);
    logic [14:0] t;
    t = w;
    t[14 - n] = b;
    return t;
  endfunction

  // Cycle-level expectation: bits counted in, fixed latency to result, held until taken.
  logic        m_busy, m_vld, m_rdy;
  int          m_cnt, m_n;
  logic [14:0] m_word;
  logic [9:0]  m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_vld <= 1'b0; m_rdy <= 1'b0;
      m_cnt <= 0; m_n <= 0; m_word <= 15'h0; m_res <= 10'h0;
    end else if (m_vld) begin
      if (ordy) begin
        m_vld <= 1'b0; m_busy <= 1'b0; m_rdy <= 1'b1;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == ((BYPASS && m_res[9]) ? 2 : 17)) m_vld <= 1'b1;
    end else if (!m_rdy) begin
      m_rdy <= 1'b1;
    end else if (ivld) begin
      m_word <= put_bit(m_word, m_n, bit_a);
      if (m_n == 14) begin
        m_res  <= model_res(put_bit(m_word, m_n, bit_a));
        m_busy <= 1'b1; m_rdy <= 1'b0; m_cnt <= 0; m_n <= 0;
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("a_in_ready", ifa.in_ready, m_rdy);
      chk("a_out_valid", ifa.out_valid, m_vld);
      chk("b_in_ready", ifb.in_ready, m_rdy);
      chk("b_out_valid", ifb.out_valid, m_vld);
      if (m_vld) begin
        chk("a_out_msg", ifa.out_msg, m_res[6:0]);
        chk("a_out_status", ifa.out_status, m_res[8:7]);
        chk("b_out_msg", ifb.out_msg, m_res[6:0]);
        chk("b_out_status", ifb.out_status, m_res[8:7]);
      end
    end
  end

  task automatic send_bits(input logic [14:0] w, input int gap_pct);
    int n, guard;
    logic rdy;
    n = 0; guard = 0;
    while (n < 15 && guard < 500) begin
      @(negedge clk);
      rdy   = m_rdy;
      ivld  = ($urandom_range(99) >= gap_pct);
      bit_a = w[14 - n];
      bit_b = w[n];
      @(posedge clk);
      if (ivld && rdy) n++;
      guard++;
    end
    @(negedge clk);
    ivld = 1'b0;
    if (n < 15) chk("send_timeout", n, 15);
  endtask

  task automatic take_result(input int hold);
    int guard;
    guard = 0;
    while (!m_vld && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("result_seen", ifa.out_valid, 1);
    repeat (hold) @(negedge clk);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] w;
    int guard, nerr, idx;

    chk("pin_01D1", model_res(15'h01D1), {1'b1, 2'd0, 7'h01});
    chk("pin_3FFF", model_res(15'h3FFF), {1'b0, 2'd1, 7'h7F});
    chk("pin_2004", model_res(15'h2004), {1'b0, 2'd2, 7'h00});
    chk("pin_0007", model_res(15'h0007), {1'b0, 2'd2, 7'h22});
    chk("pin_0000", model_res(15'h0000), {1'b1, 2'd0, 7'h00});

    repeat (3) @(negedge clk);
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_msg", ifa.out_msg, 0);
    chk("rst_out_status", ifb.out_status, 0);
    #1 rst = 1'b0;
    checking = 1'b1;

    send_bits(15'h01D1, 40); take_result(1);
    send_bits(15'h3FFF, 20); take_result(0);

    send_bits(15'h2004, 0);
    guard = 0;
    while (!(m_busy && m_cnt >= 6) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_a_out_valid", ifa.out_valid, 0);
    chk("midrst_a_in_ready", ifa.in_ready, 0);
    chk("midrst_b_out_msg", ifb.out_msg, 0);
    chk("midrst_a_out_status", ifa.out_status, 0);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    send_bits(15'h01D1, 0); take_result(0);

    send_bits(15'h2004, 10); take_result(20);
    send_bits(15'h0007, 10); take_result(2);
    send_bits(15'h0000, 0);  take_result(0);

    for (int t = 0; t < 40; t++) begin
      w    = encode(7'($urandom_range(127)));
      nerr = $urandom_range(4);
      if (nerr == 4) begin
        w = 15'($urandom);
      end else begin
        for (int e = 0; e < nerr; e++) begin
          idx = $urandom_range(14);
          w[idx] = ~w[idx];
        end
      end
      send_bits(w, $urandom_range(50));
      take_result($urandom_range(3));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
